// File: rtl/alu_op_sequencer.sv
// Sweeps an external ALU through every (seq_op, seq_cst) pair and folds each result into a rotate-XOR signature.
// Build option: define ALU_SEQ_SKIP_NOP_EN to limit the sweep to seq_op 0..4 (20 steps instead of 32).
module alu_op_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] operand,
   output logic [7:0] seq_operand,
   output logic [1:0] seq_cst,
   output logic [2:0] seq_op,
   input  logic [7:0] alu_result,
   input  logic       alu_status,
   output logic       busy,
   output logic       done,
   output logic [7:0] signature,
   output logic [5:0] status_count
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DRIVE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

`ifdef ALU_SEQ_SKIP_NOP_EN
   localparam logic [2:0] LAST_OP = 3'd4;
`else
   localparam logic [2:0] LAST_OP = 3'd7;
`endif

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0] state_q,   state_d;
   logic [3:0] settle_q,  settle_d;
   logic [7:0] operand_q, operand_d;
   logic [1:0] cst_q,     cst_d;
   logic [2:0] op_q,      op_d;
   logic [7:0] sig_q,     sig_d;
   logic [5:0] cnt_q,     cnt_d;
   logic       last_step;

   assign last_step = (op_q == LAST_OP) && (cst_q == 2'd3);

   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      operand_d = operand_q;
      cst_d     = cst_q;
      op_d      = op_q;
      sig_d     = sig_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               operand_d = operand;
               cst_d     = '0;
               op_d      = '0;
               sig_d     = '0;
               cnt_d     = '0;
               settle_d  = '0;
               state_d   = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = ST_CAPTURE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         ST_CAPTURE: begin
            sig_d = {sig_q[6:0], sig_q[7]} ^ alu_result;
            cnt_d = cnt_q + {5'd0, alu_status};
            // seq_cst is the inner index; seq_op only advances when seq_cst wraps
            if (last_step) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRIVE;
               if (cst_q == 2'd3) begin
                  cst_d = '0;
                  op_d  = op_q + 3'd1;
               end else begin
                  cst_d = cst_q + 2'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         settle_q  <= '0;
         operand_q <= '0;
         cst_q     <= '0;
         op_q      <= '0;
         sig_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         operand_q <= operand_d;
         cst_q     <= cst_d;
         op_q      <= op_d;
         sig_q     <= sig_d;
         cnt_q     <= cnt_d;
      end
   end

   assign seq_operand  = operand_q;
   assign seq_cst      = cst_q;
   assign seq_op       = op_q;
   assign signature    = sig_q;
   assign status_count = cnt_q;
   assign busy         = (state_q == ST_DRIVE) || (state_q == ST_CAPTURE);
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus queues expected sweep results and step order, a negedge monitor checks them.
// Honours ALU_SEQ_SKIP_NOP_EN the same way as the design.
module tb_alu_op_sequencer;

   localparam int unsigned S = 3;
`ifdef ALU_SEQ_SKIP_NOP_EN
   localparam int unsigned LAST_OP = 4;
`else
   localparam int unsigned LAST_OP = 7;
`endif
   localparam int unsigned N     = (LAST_OP + 1) * 4;
   localparam int unsigned SWEEP = N * (S + 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] operand = 8'h00;
   logic [7:0] seq_operand;
   logic [1:0] seq_cst;
   logic [2:0] seq_op;
   logic [7:0] alu_result;
   logic       alu_status;
   logic       busy;
   logic       done;
   logic [7:0] signature;
   logic [5:0] status_count;

   int mode = 0;

   typedef struct {
      logic [7:0] sig;
      logic [5:0] cnt;
      logic [7:0] opnd;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] step_q[$];

   int n_pass = 0;
   int n_total = 0;
   int edge_cnt = 0;
   bit b2b = 1'b0;
   int gap_checks = 0;

   alu_op_sequencer #(.SETTLE_CYCLES(S)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .operand      (operand),
      .seq_operand  (seq_operand),
      .seq_cst      (seq_cst),
      .seq_op       (seq_op),
      .alu_result   (alu_result),
      .alu_status   (alu_status),
      .busy         (busy),
      .done         (done),
      .signature    (signature),
      .status_count (status_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Stand-in ALU: tied constants or a simple function of the driven inputs
   always_comb begin
      alu_result = 8'h00;
      alu_status = 1'b0;
      case (mode)
         1: begin
            alu_result = 8'h01;
            alu_status = 1'b1;
         end
         2: begin
            alu_result = seq_operand ^ {seq_op, seq_cst, seq_op};
            alu_status = (seq_cst == seq_op[1:0]);
         end
         default: ;
      endcase
   end

   task automatic check(input string name, input int act, input int expv);
      n_total++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
   endtask

   function automatic logic [7:0] model_sig(input int m, input logic [7:0] opnd);
      logic [7:0] s;
      logic [7:0] r;
      s = 8'h00;
      if (m == 0) return 8'h00;
      if (m == 1) return (LAST_OP == 4) ? 8'h0F : 8'h00;
      for (int op = 0; op <= int'(LAST_OP); op++) begin
         for (int c = 0; c < 4; c++) begin
            r = opnd ^ {3'(op), 2'(c), 3'(op)};
            s = {s[6:0], s[7]} ^ r;
         end
      end
      return s;
   endfunction

   function automatic logic [5:0] model_cnt(input int m);
      int c;
      c = 0;
      if (m == 1) return 6'(N);
      if (m == 2) begin
         for (int op = 0; op <= int'(LAST_OP); op++)
            for (int k = 0; k < 4; k++)
               if (k == (op % 4)) c++;
      end
      return 6'(c);
   endfunction

   task automatic issue(input int m, input logic [7:0] opnd, input int sweeps);
      exp_t e;
      e.sig  = model_sig(m, opnd);
      e.cnt  = model_cnt(m);
      e.opnd = opnd;
      for (int k = 0; k < sweeps; k++) begin
         exp_q.push_back(e);
         for (int op = 0; op <= int'(LAST_OP); op++)
            for (int c = 0; c < 4; c++)
               step_q.push_back({3'(op), 2'(c)});
      end
   endtask

   task automatic pulse_start(input logic [7:0] opnd);
      @(posedge clk);
      #1 operand = opnd;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !busy && !done) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_reached", int'(ok), 1);
   endtask

   task automatic check_hold(input int m, input logic [7:0] opnd);
      repeat (3) @(posedge clk);
      #1;
      check("hold_signature", signature, model_sig(m, opnd));
      check("hold_status_count", status_count, model_cnt(m));
      check("hold_seq_operand", seq_operand, opnd);
      check("hold_seq_op", seq_op, LAST_OP);
      check("hold_seq_cst", seq_cst, 3);
      check("hold_busy", busy, 0);
   endtask

   // Monitor: step order and hold time, completion timing and result, busy gaps between back-to-back sweeps
   bit         busy_prev = 1'b0;
   bit         done_prev = 1'b0;
   bit         gap_active = 1'b0;
   int         gap = 0;
   int         run = 0;
   int         steps_seen = 0;
   int         accept_edge = 0;
   logic [4:0] prev_step = '0;
   exp_t       me;
   logic [4:0] ms;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_prev  = 1'b0;
         done_prev  = 1'b0;
         gap_active = 1'b0;
         run        = 0;
         steps_seen = 0;
      end else begin
         if (done_prev) check("done_one_cycle", int'(done), 0);
         if (busy && !busy_prev) begin
            accept_edge = edge_cnt;
            steps_seen  = 0;
            if (gap_active) begin
               check("busy_gap", gap, 2);
               gap_checks++;
            end
            gap_active = 1'b0;
         end
         if (busy) begin
            if (!busy_prev || {seq_op, seq_cst} != prev_step) begin
               if (busy_prev) check("step_hold", run, S + 1);
               check("step_expected", int'(step_q.size() > 0), 1);
               if (step_q.size() > 0) begin
                  ms = step_q.pop_front();
                  check("step_order", {seq_op, seq_cst}, ms);
               end
               steps_seen++;
               run = 1;
               prev_step = {seq_op, seq_cst};
            end else begin
               run++;
            end
         end
         if (done) begin
            check("last_step_hold", run, S + 1);
            check("step_count", steps_seen, N);
            check("done_edge", edge_cnt - accept_edge + 1, SWEEP + 1);
            check("done_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               me = exp_q.pop_front();
               check("signature", signature, me.sig);
               check("status_count", status_count, me.cnt);
               check("seq_operand", seq_operand, me.opnd);
            end
            if (b2b) begin
               gap_active = 1'b1;
               gap = 0;
            end
         end
         if (!busy && gap_active) gap++;
         busy_prev = busy;
         done_prev = done;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      int k;

      #1 rst_n = 1'b0;
      #1;
      check("rst_seq_operand", seq_operand, 0);
      check("rst_seq_cst", seq_cst, 0);
      check("rst_seq_op", seq_op, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_signature", signature, 0);
      check("rst_status_count", status_count, 0);
      #20 rst_n = 1'b1;

      // Zero ALU, operand 250
      mode = 0;
      issue(0, 8'd250, 1);
      pulse_start(8'd250);
      wait_idle(1000);
      check_hold(0, 8'd250);

      // ALU tied to 0x01 / status 1
      mode = 1;
      issue(1, 8'h5A, 1);
      pulse_start(8'h5A);
      wait_idle(1000);
      check_hold(1, 8'h5A);

      // Input-dependent ALU
      mode = 2;
      issue(2, 8'hC3, 1);
      pulse_start(8'hC3);
      wait_idle(1000);
      check_hold(2, 8'hC3);

      // Start pulses and operand changes while busy must not disturb the sweep
      mode = 1;
      issue(1, 8'h11, 1);
      pulse_start(8'h11);
      repeat (20) @(posedge clk);
      #1 operand = 8'h77;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle(1000);
      check_hold(1, 8'h11);
      repeat (6) @(posedge clk);
      #1 check("no_restart_busy", busy, 0);

      // Reset during step 10 DRIVE aborts without a done pulse
      mode = 1;
      issue(1, 8'h99, 1);
      pulse_start(8'h99);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (busy && seq_op == 3'd2 && seq_cst == 2'd2) begin
            found = 1'b1;
            break;
         end
      end
      check("reach_step10", int'(found), 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_seq_operand", seq_operand, 0);
      check("abort_seq_cst", seq_cst, 0);
      check("abort_seq_op", seq_op, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_signature", signature, 0);
      check("abort_status_count", status_count, 0);
      exp_q.delete();
      step_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_abort_busy", busy, 0);
      check("post_abort_done", done, 0);
      mode = 2;
      issue(2, 8'h42, 1);
      pulse_start(8'h42);
      wait_idle(1000);
      check_hold(2, 8'h42);

      // start held high for 200 edges: back-to-back sweeps
      k = 0;
      while (k * int'(SWEEP + 2) < 200) k++;
      mode = 1;
      issue(1, 8'hA5, k);
      b2b = 1'b1;
      gap_active = 1'b0;
      gap_checks = 0;
      @(posedge clk);
      #1 operand = 8'hA5;
      start = 1'b1;
      repeat (200) @(posedge clk);
      #1 start = 1'b0;
      wait_idle(2000);
      b2b = 1'b0;
      check("b2b_gap_checks", gap_checks, k - 1);
      check_hold(1, 8'hA5);

      check("queues_drained", exp_q.size() + step_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
